mem_stage_lsu: RTL and testbench

Memory-stage load/store unit. It consumes the M-stage signals produced by the execute/memory pipeline register (ALUResultM, WriteDataM, WA3M, PCSrcM, RegWriteM, MemWriteM, MemtoRegM). It drives the data-memory request/acknowledge bus and stalls the pipeline until the access completes. It registers the memory-to-writeback stage outputs consumed by the register-file write port.

---
 rtl/mem_stage_pkg.sv | 14 +
 rtl/lsu_timeout_ctr.sv | 27 ++
 rtl/mem_stage_lsu.sv | 162 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory-stage load/store unit.
// The optional access timeout is enabled with the MEM_TIMEOUT_EN macro.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

  localparam int REGADDR_W_DEF = 4;
  localparam int TIMEOUT_DEF   = 16;

endpackage

// File: rtl/lsu_timeout_ctr.sv
// Cycle counter for an outstanding data-memory access.
// Used by mem_stage_lsu only when MEM_TIMEOUT_EN is defined.
// expire fires in the cycle whose increment would bring the count to TIMEOUT.
module lsu_timeout_ctr #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  // Count waiting cycles; saturate at TIMEOUT so the value never wraps.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != CNT_W'(TIMEOUT))) begin
      count <= count + 1'b1;
    end
  end

  assign expire = inc && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues data-memory requests for loads and
// stores, stalls the pipeline until the access completes, and registers the
// M->W outputs for the register-file write port.
// Optional feature: MEM_TIMEOUT_EN adds an ACCESS timeout with a sticky
// timeout_err flag; without it ACCESS waits for dmem_ack indefinitely.
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REGADDR_W = REGADDR_W_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     ALUResultM,
  input  logic [WIDTH-1:0]     WriteDataM,
  input  logic [REGADDR_W-1:0] WA3M,
  input  logic                 PCSrcM,
  input  logic                 RegWriteM,
  input  logic                 MemWriteM,
  input  logic                 MemtoRegM,
  output logic                 StallM,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [WIDTH-1:0]     dmem_addr,
  output logic [WIDTH-1:0]     dmem_wdata,
  input  logic [WIDTH-1:0]     dmem_rdata,
  input  logic                 dmem_ack,
  output logic [WIDTH-1:0]     ReadDataW,
  output logic [WIDTH-1:0]     ALUOutW,
  output logic [REGADDR_W-1:0] WA3W,
  output logic                 PCSrcW,
  output logic                 RegWriteW,
  output logic                 MemtoRegW,
  output logic                 timeout_err
);

  lsu_state_t       state;
  logic             memop;
  logic             is_load;
  logic [WIDTH-1:0] rdata_q;
  logic             expire;
  logic             aborted;

  // A simultaneous write+load request is treated as a store.
  assign memop   = MemWriteM | MemtoRegM;
  assign is_load = MemtoRegM & ~MemWriteM;

  assign StallM = !reset && ((state == ACCESS) || ((state == IDLE) && memop));

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] unused_tmo_count;
  logic             abort_q;
  logic             tmo_q;

  lsu_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == IDLE),
    .inc    ((state == ACCESS) && !dmem_ack),
    .count  (unused_tmo_count),
    .expire (expire)
  );

  // Remember an aborted access until it retires, and latch the sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      abort_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else if ((state == ACCESS) && !dmem_ack && expire) begin
      abort_q <= 1'b1;
      tmo_q   <= 1'b1;
    end else if (state == DONE) begin
      abort_q <= 1'b0;
    end
  end

  assign aborted     = abort_q;
  assign timeout_err = tmo_q;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT > 0);
  assign expire         = 1'b0;
  assign aborted        = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  // Sequencer: drives the memory bus and the W-stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rdata_q    <= '0;
      ReadDataW  <= '0;
      ALUOutW    <= '0;
      WA3W       <= '0;
      PCSrcW     <= 1'b0;
      RegWriteW  <= 1'b0;
      MemtoRegW  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ALUOutW <= ALUResultM;
          WA3W    <= WA3M;
          if (memop) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWriteM;
            dmem_addr  <= ALUResultM;
            dmem_wdata <= WriteDataM;
            PCSrcW     <= 1'b0;
            RegWriteW  <= 1'b0;
            MemtoRegW  <= 1'b0;
            state      <= ACCESS;
          end else begin
            PCSrcW    <= PCSrcM;
            RegWriteW <= RegWriteM;
            MemtoRegW <= MemtoRegM;
          end
        end
        ACCESS: begin
          PCSrcW    <= 1'b0;
          RegWriteW <= 1'b0;
          MemtoRegW <= 1'b0;
          if (dmem_ack) begin
            if (!dmem_we) begin
              rdata_q <= dmem_rdata;
            end
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            state    <= DONE;
          end else if (expire) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          ALUOutW   <= ALUResultM;
          WA3W      <= WA3M;
          PCSrcW    <= PCSrcM;
          RegWriteW <= RegWriteM & ~aborted;
          MemtoRegW <= is_load & ~aborted;
          if (is_load && !aborted) begin
            ReadDataW <= rdata_q;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: the bench plays the data memory
// (word store keyed by address) and predicts each instruction's bus traffic,
// stall length and W-stage result at the transaction level.
module tb_mem_stage_lsu;

  localparam int W   = 32;
  localparam int RW  = 4;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  ALUResultM, WriteDataM;
  logic [RW-1:0] WA3M;
  logic          PCSrcM, RegWriteM, MemWriteM, MemtoRegM;
  logic          StallM;
  logic          dmem_req, dmem_we;
  logic [W-1:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic          dmem_ack;
  logic [W-1:0]  ReadDataW, ALUOutW;
  logic [RW-1:0] WA3W;
  logic          PCSrcW, RegWriteW, MemtoRegW;
  logic          timeout_err;

  mem_stage_lsu #(.WIDTH(W), .REGADDR_W(RW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .StallM(StallM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WA3W(WA3W),
    .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [31:0]  mem [logic [31:0]];
  logic [31:0]  exp_rd;
  logic         exp_tmo;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wa,
                       input logic pc, input logic rw, input logic mw, input logic mtr);
    ALUResultM = a;  WriteDataM = wd; WA3M = wa;
    PCSrcM = pc; RegWriteM = rw; MemWriteM = mw; MemtoRegM = mtr;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},   32'(dmem_req), 32'd0);
    chk({tag, "_we"},    32'(dmem_we), 32'd0);
    chk({tag, "_addr"},  dmem_addr, 32'd0);
    chk({tag, "_wdata"}, dmem_wdata, 32'd0);
    chk({tag, "_rd"},    ReadDataW, 32'd0);
    chk({tag, "_alu"},   ALUOutW, 32'd0);
    chk({tag, "_wa3"},   32'(WA3W), 32'd0);
    chk({tag, "_pcs"},   32'(PCSrcW), 32'd0);
    chk({tag, "_rw"},    32'(RegWriteW), 32'd0);
    chk({tag, "_m2r"},   32'(MemtoRegW), 32'd0);
    chk({tag, "_tmo"},   32'(timeout_err), 32'd0);
  endtask

  // One instruction from presentation to its W-stage result; lat is the
  // number of request cycles before ack (negative: never acknowledged).
  // Called and returns at negedge+1.
  task automatic do_op(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wa,
                       input logic pc, input logic rw, input logic mw, input logic mtr,
                       input int lat);
    int   stall;
    int   nreq;
    logic acked;
    logic ab;
    stall = 0; nreq = 0; acked = 1'b0; ab = 1'b0;
    drive(a, wd, wa, pc, rw, mw, mtr);
    #1;
    if (!(mw | mtr)) begin
      chk("alu_stall", 32'(StallM), 32'd0);
      chk("alu_req", 32'(dmem_req), 32'd0);
      @(negedge clk); #1;
    end else begin
      while (StallM === 1'b1 && stall < 64) begin
        stall++;
        if (dmem_req === 1'b1) begin
          chk("req_addr", dmem_addr, a);
          chk("req_we", 32'(dmem_we), 32'(mw));
          chk("req_wdata", dmem_wdata, wd);
          chk("bubble_rw", 32'(RegWriteW), 32'd0);
          if (nreq == lat) begin
            dmem_ack = 1'b1;
            if (mw) begin
              dmem_rdata = $urandom;
              mem[a] = wd;
            end else begin
              dmem_rdata = mem_rd(a);
            end
            acked = 1'b1;
          end
          nreq++;
        end
        @(negedge clk);
        dmem_ack = 1'b0;
        dmem_rdata = $urandom;
        #1;
      end
      ab = (lat < 0);
      if (ab) exp_tmo = 1'b1;
      chk("stall_cycles", 32'(stall), ab ? 32'(TMO + 1) : 32'(lat + 2));
      chk("req_cycles", 32'(nreq), ab ? 32'(TMO) : 32'(lat + 1));
      chk("done_req", 32'(dmem_req), 32'd0);
      if (acked && !mw) exp_rd = mem_rd(a);
      @(negedge clk); #1;
    end
    chk("w_alu", ALUOutW, a);
    chk("w_wa3", 32'(WA3W), 32'(wa));
    chk("w_pcs", 32'(PCSrcW), 32'(pc));
    chk("w_rw", 32'(RegWriteW), 32'(rw & ~ab));
    chk("w_m2r", 32'(MemtoRegW), 32'(mtr & ~mw & ~ab));
    chk("w_rd", ReadDataW, exp_rd);
    chk("w_tmo", 32'(timeout_err), 32'(exp_tmo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    exp_rd = '0;
    exp_tmo = 1'b0;
    drive($urandom, $urandom, 4'($urandom_range(0, 15)), 1'b1, 1'b1, 1'b1, 1'b1);

    // Reset held two cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive($urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      #1;
      chk("rst_stall", 32'(StallM), 32'd0);
    end
    chk_zero("rst");
    reset = 1'b0;
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;

    // ALU op, load with immediate ack, store with delayed ack.
    do_op(32'h10, $urandom, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    mem[32'h100] = 32'hDEADBEEF;
    do_op(32'h100, $urandom, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    do_op(32'h44, $urandom, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    do_op(32'h200, 32'h12345678, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3);
    do_op(32'h200, $urandom, 4'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    do_op(32'h300, 32'hCAFEF00D, 4'd8, 1'b0, 1'b1, 1'b1, 1'b1, 2);

    // Reset in the second ACCESS cycle, then a late ack.
    drive(32'h340, $urandom, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk); #1;
    chk("mid_req1", 32'(dmem_req), 32'd1);
    @(negedge clk); #1;
    chk("mid_req2", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("mid_rst_stall", 32'(StallM), 32'd0);
    @(negedge clk); #1;
    chk_zero("mid_rst");
    reset = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hBADC0DE5;
    #1;
    chk("late_ack_stall", 32'(StallM), 32'd0);
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    chk("late_ack_req", 32'(dmem_req), 32'd0);
    chk("late_ack_rd", ReadDataW, 32'd0);
    exp_rd = '0;

    // Randomized instruction mix over a small address pool.
    for (int i = 0; i < 150; i++) begin
      int k;
      logic [31:0] a;
      k = $urandom_range(0, 3);
      a = 32'($urandom_range(0, 15)) << 2;
      do_op(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), (k >= 2), (k == 1 || k == 3), $urandom_range(0, 4));
    end

`ifdef MEM_TIMEOUT_EN
    // Unacknowledged load aborts; the error flag stays set until reset.
    do_op(32'h3C, $urandom, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    do_op(32'h20, 32'h0BADF00D, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    do_op(32'h24, $urandom, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    reset = 1'b1;
    @(negedge clk); #1;
    chk_zero("tmo_rst");
    reset = 1'b0;
    exp_rd = '0;
    exp_tmo = 1'b0;
    do_op(32'h28, $urandom, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
